pe_onehot_decoder: RTL and testbench



---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_dwell_counter.sv | 40 ++++
 rtl/pe_onehot_decoder.sv | 139 +++++++++++++
 tb/tb_pe_onehot_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the one-hot decoder.
//   pe_dec_state_e : decoder FSM states (IDLE, HOLD, GAP)
//   PE_CNT_W       : width of the dwell counter (HOLD/GAP lengths up to 255)
//   PE_MAX_IDX_W   : widest index onehot() supports (N up to 256)
//   onehot()       : expands an index/zero-flag pair to a one-hot word
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } pe_dec_state_e;

    localparam int unsigned PE_CNT_W     = 8;
    localparam int unsigned PE_MAX_IDX_W = 8;
    localparam int unsigned PE_MAX_N     = 2 ** PE_MAX_IDX_W;

    // Callers truncate the result to their own N = 2**IDX_W.
    function automatic logic [PE_MAX_N-1:0] onehot(input logic [PE_MAX_IDX_W-1:0] idx,
                                                   input logic                    zero);
        logic [PE_MAX_N-1:0] word;
        word = '0;
        if (!zero) begin
            word[idx] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/pe_dwell_counter.sv
// Loadable down-counter with a zero flag; times both the HOLD and GAP phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val this cycle (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (ignored when already zero)
//   zero       : count is zero
module pe_dwell_counter
    import pe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PE_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [PE_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pe_onehot_decoder.sv
// Expands an encoded index (+ none-active flag) into a one-hot word, holds it for
// HOLD_CYC cycles, then drives GAP_CYC all-zero cycles before accepting the next code.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : code present
//   in_ready    : decoder accepts a code this cycle (IDLE only)
//   in_code     : encoded index
//   in_zero     : no line active; decode to an all-zero (but valid) word
//   out_onehot  : registered decoded word
//   out_valid   : high while a decoded word is held
//   busy        : high in HOLD or GAP
//   word_cnt    : accepts seen, wraps at 16 bits (PE_DEC_WORD_COUNT_EN only)
//   zero_cnt    : accepts with in_zero set, wraps at 16 bits (PE_DEC_WORD_COUNT_EN only)
// Optional feature: define PE_DEC_WORD_COUNT_EN to add word_cnt / zero_cnt.
module pe_onehot_decoder
    import pe_pkg::*;
#(
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned GAP_CYC  = 1,
    localparam int unsigned N       = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_code,
    input  logic             in_zero,
    output logic [N-1:0]     out_onehot,
    output logic             out_valid,
`ifdef PE_DEC_WORD_COUNT_EN
    output logic [15:0]      word_cnt,
    output logic [15:0]      zero_cnt,
`endif
    output logic             busy
);

    localparam logic [PE_CNT_W-1:0] HOLD_LOAD = PE_CNT_W'(HOLD_CYC - 1);
    // GAP_LOAD is never used when GAP_CYC == 0; keep it well-defined anyway.
    localparam logic [PE_CNT_W-1:0] GAP_LOAD  =
        (GAP_CYC == 0) ? '0 : PE_CNT_W'(GAP_CYC - 1);

    pe_dec_state_e state_q;
    logic          accept;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [PE_CNT_W-1:0] cnt_val;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;

    // Counter control: load on phase entry, count down inside a phase.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (GAP_CYC != 0) begin
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LOAD;
                end
            end
            GAP: begin
                cnt_dec = !cnt_zero;
            end
            default: ;
        endcase
    end

    pe_dwell_counter u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_onehot <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_onehot <= N'(onehot(PE_MAX_IDX_W'(in_code), in_zero));
                        out_valid  <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        out_onehot <= '0;
                        out_valid  <= 1'b0;
                        state_q    <= (GAP_CYC == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    out_onehot <= '0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_DEC_WORD_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            zero_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 16'd1;
            if (in_zero) begin
                zero_cnt <= zero_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_onehot_decoder.sv
module tb_pe_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst_n;

    // u0: IDX_W=2, HOLD_CYC=2, GAP_CYC=1
    logic       in_valid, in_ready, in_zero, out_valid, busy;
    logic [1:0] in_code;
    logic [3:0] out_onehot;
`ifdef PE_DEC_WORD_COUNT_EN
    logic [15:0] word_cnt, zero_cnt, word_cnt1, zero_cnt1;
`endif

    // u1: IDX_W=2, HOLD_CYC=1, GAP_CYC=0
    logic       in_valid1, in_ready1, in_zero1, out_valid1, busy1;
    logic [1:0] in_code1;
    logic [3:0] out_onehot1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_onehot_decoder #(.IDX_W(2), .HOLD_CYC(2), .GAP_CYC(1)) u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_zero    (in_zero),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
`ifdef PE_DEC_WORD_COUNT_EN
        .word_cnt   (word_cnt),
        .zero_cnt   (zero_cnt),
`endif
        .busy       (busy)
    );

    pe_onehot_decoder #(.IDX_W(2), .HOLD_CYC(1), .GAP_CYC(0)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_code    (in_code1),
        .in_zero    (in_zero1),
        .out_onehot (out_onehot1),
        .out_valid  (out_valid1),
`ifdef PE_DEC_WORD_COUNT_EN
        .word_cnt   (word_cnt1),
        .zero_cnt   (zero_cnt1),
`endif
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        in_zero   = 1'b0;
        in_valid1 = 1'b0;
        in_code1  = 2'd0;
        in_zero1  = 1'b0;
        #12;
        check("rst_onehot", 32'(out_onehot), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(in_ready), 32'h1);

        // Single decode: code 3 -> 1000 for 2 cycles, 1 gap cycle, then ready.
        in_valid = 1'b1; in_code = 2'd3; in_zero = 1'b0;
        step();
        in_valid = 1'b0;
        check("single_k0_onehot", 32'(out_onehot), 32'h8);
        check("single_k0_valid", 32'(out_valid), 32'h1);
        check("single_k0_busy", 32'(busy), 32'h1);
        check("single_k0_ready", 32'(in_ready), 32'h0);
        step();
        check("single_k1_onehot", 32'(out_onehot), 32'h8);
        check("single_k1_valid", 32'(out_valid), 32'h1);
        step();
        check("single_gap_onehot", 32'(out_onehot), 32'h0);
        check("single_gap_valid", 32'(out_valid), 32'h0);
        check("single_gap_busy", 32'(busy), 32'h1);
        check("single_gap_ready", 32'(in_ready), 32'h0);
        step();
        check("single_idle_ready", 32'(in_ready), 32'h1);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Zero flag: valid word of all zeros for 2 cycles.
        in_valid = 1'b1; in_code = 2'd0; in_zero = 1'b1;
        step();
        in_valid = 1'b0; in_zero = 1'b0;
        check("zero_k0_valid", 32'(out_valid), 32'h1);
        check("zero_k0_onehot", 32'(out_onehot), 32'h0);
        step();
        check("zero_k1_valid", 32'(out_valid), 32'h1);
        check("zero_k1_onehot", 32'(out_onehot), 32'h0);
        step();
        check("zero_end_valid", 32'(out_valid), 32'h0);
        step();

        // Contrast: code 0 without zero flag -> 0001.
        in_valid = 1'b1; in_code = 2'd0; in_zero = 1'b0;
        step();
        in_valid = 1'b0;
        check("code0_onehot", 32'(out_onehot), 32'h1);
        check("code0_valid", 32'(out_valid), 32'h1);
        step(); step(); step();
        check("code0_idle_ready", 32'(in_ready), 32'h1);

        // Back-to-back: in_valid held, codes 2 then 1, accepts 4 cycles apart.
        in_valid = 1'b1; in_code = 2'd2;
        step();
        check("b2b_a_onehot", 32'(out_onehot), 32'h4);
        in_code = 2'd1;
        step();
        check("b2b_a_hold", 32'(out_onehot), 32'h4);
        step();
        check("b2b_gap", 32'(out_onehot), 32'h0);
        step();
        check("b2b_idle_valid", 32'(out_valid), 32'h0);
        check("b2b_idle_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("b2b_b_onehot", 32'(out_onehot), 32'h2);
        check("b2b_b_valid", 32'(out_valid), 32'h1);
        step(); step(); step();
        check("b2b_done_ready", 32'(in_ready), 32'h1);

`ifdef PE_DEC_WORD_COUNT_EN
        check("word_cnt", 32'(word_cnt), 32'd5);
        check("zero_cnt", 32'(zero_cnt), 32'd1);
`endif

        // Asynchronous reset in the middle of HOLD.
        in_valid = 1'b1; in_code = 2'd1;
        step();
        in_valid = 1'b0;
        check("arst_pre_onehot", 32'(out_onehot), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_onehot", 32'(out_onehot), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
`ifdef PE_DEC_WORD_COUNT_EN
        check("arst_word_cnt", 32'(word_cnt), 32'd0);
`endif
        #2 rst_n = 1'b1;
        check("arst_ready", 32'(in_ready), 32'h1);
        step();

        // u1 (HOLD 1, GAP 0): continuous codes -> one word every 2 cycles.
        in_valid1 = 1'b1; in_code1 = 2'd3; in_zero1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("g0_valid", 32'(out_valid1), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("g0_onehot", 32'(out_onehot1), (i % 2 == 0) ? 32'h8 : 32'h0);
        end
        in_valid1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
